noc_link_channel_mux: RTL

//   Generalised tile-to-NoC link stage: merges CHANNELS independent flit streams
//   (valid/ready/last) onto one physical output link. Per-channel FIFO buffering

---
 rtl/noc_link_channel_mux.sv | 88 ++++++++
 1 files changed

// File: rtl/noc_link_channel_mux.sv
// noc_link_channel_mux: per-channel flit FIFOs merged onto one link by packet-atomic round-robin.
// Define NOC_MUX_STATS_EN to add stat_clr_i / stat_pkt_cnt_o per-channel packet counters.
module noc_link_channel_mux #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS = 2,
  parameter int DEPTH = 4,
  parameter int CNT_WIDTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS*FLIT_WIDTH-1:0] in_flit_i,
  input  logic [CHANNELS-1:0]            in_last_i,
  input  logic [CHANNELS-1:0]            in_valid_i,
  output logic [CHANNELS-1:0]            in_ready_o,
  output logic [FLIT_WIDTH-1:0]          out_flit_o,
  output logic                           out_last_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [CW-1:0]                  out_channel_o
`ifdef NOC_MUX_STATS_EN
  ,
  input  logic                           stat_clr_i,
  output logic [CHANNELS*CNT_WIDTH-1:0]  stat_pkt_cnt_o
`endif
);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state_q;
  logic [CW-1:0] grant_q, grant_d, rr_q;
  logic [CHANNELS-1:0] empty;
  logic [FLIT_WIDTH:0] head [CHANNELS];
  logic [FLIT_WIDTH:0] hd;
  logic pop;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [AW:0] wptr_q, rptr_q;
    logic [FLIT_WIDTH:0] mem_q [DEPTH];
    logic wr;
    assign in_ready_o[c] = !((wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]));
    assign empty[c] = wptr_q == rptr_q;
    assign wr = in_valid_i[c] && in_ready_o[c];
    assign head[c] = mem_q[rptr_q[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (wr) wptr_q <= wptr_q + 1'b1;
        if (pop && grant_q == CW'(c)) rptr_q <= rptr_q + 1'b1;
      end
    always_ff @(posedge clk)
      if (wr) mem_q[wptr_q[AW-1:0]] <= {in_last_i[c], in_flit_i[c*FLIT_WIDTH +: FLIT_WIDTH]};
`ifdef NOC_MUX_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else if (stat_clr_i) cnt_q <= '0;
      else if (pop && out_last_o && grant_q == CW'(c)) cnt_q <= cnt_q + 1'b1;
    assign stat_pkt_cnt_o[c*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
`endif
  end
  // Descending scan so the nearest non-empty channel after rr_q is the final assignment.
  always_comb begin
    grant_d = rr_q;
    for (int i = CHANNELS; i >= 1; i--)
      if (!empty[(int'(rr_q) + i) % CHANNELS]) grant_d = CW'((int'(rr_q) + i) % CHANNELS);
  end
  assign hd = head[grant_q];
  assign out_valid_o = state_q == XFER && !empty[grant_q];
  assign out_flit_o = out_valid_o ? hd[FLIT_WIDTH-1:0] : '0;
  assign out_last_o = out_valid_o && hd[FLIT_WIDTH];
  assign out_channel_o = grant_q;
  assign pop = out_valid_o && out_ready_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q <= CW'(CHANNELS - 1);
    end else if (state_q == IDLE) begin
      if (!(&empty)) begin
        grant_q <= grant_d;
        state_q <= XFER;
      end
    end else if (pop && out_last_o) begin
      rr_q <= grant_q;
      state_q <= IDLE;
    end
endmodule
